// File: rtl/iob_sp_ram_be_ctrl_pkg.sv
// Shared definitions for the byte-enable single-port RAM request controller.
//   state_e      : controller FSM encoding (INIT / CLEAR / RUN, 2 bits)
//   calc_data_w  : data word width from column count and column width
package iob_sp_ram_be_ctrl_pkg;

    localparam int unsigned StateWidth = 2;

    typedef enum logic [StateWidth-1:0] {
        StInit  = 2'd0,
        StClear = 2'd1,
        StRun   = 2'd2
    } state_e;

    // One data word is NUM_COL byte columns laid side by side.
    function automatic int unsigned calc_data_w(input int unsigned num_col,
                                                input int unsigned col_width);
        return num_col * col_width;
    endfunction

endpackage

// File: rtl/iob_sp_ram_be_ctrl.sv
// Request-side controller for a read-first, 1-cycle-latency byte-enable single-port RAM.
// Turns a valid/ready request stream into RAM en/we/addr/din strobes, returns one response
// per request (rdata straight from ram_dout, i.e. the pre-write word for writes) and zero-fills
// the whole RAM after reset (INIT_CLEAR=1) or on a clear_req pulse.
//
// Ports
//   clk, rst_n            : clock (posedge), asynchronous active-low reset
//   clear_req             : pulse requesting a zero-fill; honoured only in RUN
//   req_valid/req_ready   : request handshake; req_addr/req_wdata/req_wstrb (wstrb=0 is a read)
//   resp_valid/resp_ready : response handshake; resp_rdata mirrors ram_dout
//   busy                  : high while initialising or clearing
//   ram_en/we/addr/din    : strobes to the RAM; ram_dout is its read data
module iob_sp_ram_be_ctrl
    import iob_sp_ram_be_ctrl_pkg::*;
#(
    parameter int unsigned NUM_COL    = 4,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter bit          INIT_CLEAR = 1'b1,
    localparam int unsigned DATA_W    = calc_data_w(NUM_COL, COL_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [NUM_COL-1:0]    req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  busy,
    output logic                  ram_en,
    output logic [NUM_COL-1:0]    ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_din,
    input  logic [DATA_W-1:0]     ram_dout
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  pend_q, pend_d;
    logic                  clr_pend_q, clr_pend_d;

    logic                  accept;
    logic                  drain_ok;

    // A pending response is either absent or being consumed this cycle.
    assign drain_ok = !pend_q || resp_ready;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        pend_d     = pend_q;
        clr_pend_d = clr_pend_q;
        req_ready  = 1'b0;
        accept     = 1'b0;
        ram_en     = 1'b0;
        ram_we     = '0;
        ram_addr   = '0;
        ram_din    = '0;

        unique case (state_q)
            StInit: begin
                state_d = INIT_CLEAR ? StClear : StRun;
            end

            StClear: begin
                ram_en    = 1'b1;
                ram_we    = '1;
                ram_addr  = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + 1'b1;  // wraps to 0 after the last word
                if (clr_cnt_q == '1) begin
                    state_d = StRun;
                end
            end

            StRun: begin
                req_ready = !clr_pend_q && drain_ok;
                accept    = req_valid && req_ready;

                if (accept) begin
                    ram_en   = 1'b1;
                    ram_we   = req_wstrb;
                    ram_addr = req_addr;
                    ram_din  = req_wdata;
                    pend_d   = 1'b1;
                end else if (resp_ready) begin
                    pend_d = 1'b0;
                end

                // Registered so a request accepted alongside clear_req still completes first.
                if (clear_req) begin
                    clr_pend_d = 1'b1;
                end

                // Enter CLEAR only once the outstanding response has been (or is being) taken.
                if (clr_pend_q && drain_ok) begin
                    clr_pend_d = 1'b0;
                    pend_d     = 1'b0;
                    state_d    = StClear;
                end
            end

            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            clr_cnt_q  <= '0;
            pend_q     <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            pend_q     <= pend_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    assign resp_valid = pend_q;
    assign resp_rdata = ram_dout;
    assign busy       = (state_q != StRun);

endmodule
